// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: one instance per port (A = CPU, B = loader/debug).
// The requester holds req high until its done pulse.
interface sram_arbiter_if;
  logic        req;
  logic        we;
  logic [19:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        done;
  logic        gnt;

  modport master (output req, we, addr, wdata, input rdata, done, gnt);
  modport slave  (input req, we, addr, wdata, output rdata, done, gnt);
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for an asynchronous 16-bit SRAM.
// Each access runs IDLE -> ACCESS (ACCESS_CYCLES cycles) -> DONE, with fixed latency.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2  // legal range 1..15
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sram_arbiter_if.slave io_a,
  sram_arbiter_if.slave io_b,
  output logic          o_ce_n,
  output logic          o_ub_n,
  output logic          o_lb_n,
  output logic          o_oe_n,
  output logic          o_we_n,
  output logic [19:0]   o_addr,
  inout  wire  [15:0]   io_data
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_grant;
  logic        w_grant_b;
  logic        w_capture;

  logic        r_last_b;
  logic        r_sel_b;
  logic        r_we_lat;
  logic [19:0] r_addr_lat;
  logic [15:0] r_wdata_lat;
  logic        w_sel_b_next;
  logic        w_we_next;
  logic [19:0] w_addr_lat_next;
  logic [15:0] w_wdata_lat_next;
  logic        w_access_next;

  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_drive;
  logic [19:0] r_addr;
  logic        r_a_gnt;
  logic        r_b_gnt;
  logic        r_a_done;
  logic        r_b_done;
  logic [15:0] r_a_rdata;
  logic [15:0] r_b_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // With both ports requesting, the port not served last wins.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_grant      = 1'b0;
    w_grant_b    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_a.req || io_b.req) begin
          w_grant      = 1'b1;
          w_grant_b    = io_b.req && (!io_a.req || !r_last_b);
          w_state_next = S_ACCESS;
          w_cnt_next   = CNT_INIT;
        end
      end
      S_ACCESS: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_sel_b_next     = r_sel_b;
    w_we_next        = r_we_lat;
    w_addr_lat_next  = r_addr_lat;
    w_wdata_lat_next = r_wdata_lat;
    if (w_grant) begin
      w_sel_b_next     = w_grant_b;
      w_we_next        = w_grant_b ? io_b.we    : io_a.we;
      w_addr_lat_next  = w_grant_b ? io_b.addr  : io_a.addr;
      w_wdata_lat_next = w_grant_b ? io_b.wdata : io_a.wdata;
    end
    w_access_next = (w_state_next == S_ACCESS);
    w_capture     = (r_state == S_ACCESS) && (r_cnt == 4'd1) && !r_we_lat;
  end

  // Strobes are registered from the next state so the SRAM never sees decode glitches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_b    <= 1'b1;
      r_sel_b     <= 1'b0;
      r_we_lat    <= 1'b0;
      r_addr_lat  <= 20'd0;
      r_wdata_lat <= 16'd0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_drive     <= 1'b0;
      r_addr      <= 20'd0;
      r_a_gnt     <= 1'b0;
      r_b_gnt     <= 1'b0;
      r_a_done    <= 1'b0;
      r_b_done    <= 1'b0;
      r_a_rdata   <= 16'd0;
      r_b_rdata   <= 16'd0;
    end else begin
      if (w_grant) begin
        r_last_b <= w_grant_b;
      end
      r_sel_b     <= w_sel_b_next;
      r_we_lat    <= w_we_next;
      r_addr_lat  <= w_addr_lat_next;
      r_wdata_lat <= w_wdata_lat_next;
      r_ce_n      <= !w_access_next;
      r_oe_n      <= !(w_access_next && !w_we_next);
      r_we_n      <= !(w_access_next && w_we_next);
      r_drive     <= w_access_next && w_we_next;
      r_addr      <= w_access_next ? w_addr_lat_next : 20'd0;
      r_a_gnt     <= (w_state_next != S_IDLE) && !w_sel_b_next;
      r_b_gnt     <= (w_state_next != S_IDLE) && w_sel_b_next;
      r_a_done    <= (w_state_next == S_DONE) && !w_sel_b_next;
      r_b_done    <= (w_state_next == S_DONE) && w_sel_b_next;
      if (w_capture && !r_sel_b) begin
        r_a_rdata <= io_data;
      end
      if (w_capture && r_sel_b) begin
        r_b_rdata <= io_data;
      end
    end
  end

  assign io_data    = r_drive ? r_wdata_lat : 16'bz;
  assign o_ce_n     = r_ce_n;
  assign o_ub_n     = r_ce_n;
  assign o_lb_n     = r_ce_n;
  assign o_oe_n     = r_oe_n;
  assign o_we_n     = r_we_n;
  assign o_addr     = r_addr;
  assign io_a.gnt   = r_a_gnt;
  assign io_b.gnt   = r_b_gnt;
  assign io_a.done  = r_a_done;
  assign io_b.done  = r_b_done;
  assign io_a.rdata = r_a_rdata;
  assign io_b.rdata = r_b_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model on the bus, transaction-timestamp reference model,
// per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_sram_arbiter;
  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_n, ub_n, lb_n, oe_n, we_n;
  logic [19:0] addr_o;
  wire  [15:0] sram_data;

  sram_arbiter_if ia ();
  sram_arbiter_if ib ();

  sram_arbiter #(.ACCESS_CYCLES(N)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_a   (ia),
    .io_b   (ib),
    .o_ce_n (ce_n),
    .o_ub_n (ub_n),
    .o_lb_n (lb_n),
    .o_oe_n (oe_n),
    .o_we_n (we_n),
    .o_addr (addr_o),
    .io_data(sram_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Address space folded to 64 words: bit 19 plus bits 4:0.
  function automatic logic [5:0] midx(input logic [19:0] a);
    return {a[19], a[4:0]};
  endfunction

  function automatic logic [15:0] minit(input int i);
    return 16'hA500 ^ (16'(i) * 16'h0101);
  endfunction

  // SRAM model; the bench reloads its contents on every reset so model and SRAM restart equal.
  logic [15:0] sram_mem [64];
  assign sram_data = (!ce_n && !oe_n && we_n) ? sram_mem[midx(addr_o)] : 16'bz;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= minit(i);
    end else if (!ce_n && !we_n) begin
      sram_mem[midx(addr_o)] <= sram_data;
    end
  end

  // Reference model: each access is a record with a grant timestamp m_g (edge count).
  int          e = 0;
  int          m_g = 0;
  bit          m_active = 1'b0;
  bit          m_last_b = 1'b1;
  bit          m_b = 1'b0;
  bit          m_we = 1'b0;
  logic [19:0] m_addr = 20'd0;
  logic [15:0] m_wdata = 16'd0;
  logic [15:0] m_rd_a = 16'd0;
  logic [15:0] m_rd_b = 16'd0;
  logic [15:0] ref_mem [64];
  bit          chk_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0;
        m_last_b = 1'b1;
        m_rd_a   = 16'd0;
        m_rd_b   = 16'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = minit(i);
      end else begin
        e++;
        if (m_active && e == m_g + N && !m_we) begin
          if (m_b) m_rd_b = ref_mem[midx(m_addr)];
          else     m_rd_a = ref_mem[midx(m_addr)];
        end
        if (!m_active || e >= m_g + N + 2) begin
          m_active = 1'b0;
          if (ia.req || ib.req) begin
            if (ia.req && ib.req) m_b = !m_last_b;
            else                  m_b = ib.req;
            m_last_b = m_b;
            m_active = 1'b1;
            m_g      = e;
            m_we     = m_b ? ib.we    : ia.we;
            m_addr   = m_b ? ib.addr  : ia.addr;
            m_wdata  = m_b ? ib.wdata : ia.wdata;
            if (m_we) ref_mem[midx(m_addr)] = m_wdata;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit acc;
    bit dn;
    if (!rst && chk_en) begin
      acc = m_active && (e >= m_g) && (e < m_g + N);
      dn  = m_active && (e == m_g + N);
      check_eq("strobes", {27'd0, ce_n, ub_n, lb_n, oe_n, we_n},
               {27'd0, !acc, !acc, !acc, !(acc && !m_we), !(acc && m_we)});
      check_eq("gnt", {30'd0, ia.gnt, ib.gnt}, {30'd0, (acc || dn) && !m_b, (acc || dn) && m_b});
      check_eq("done", {30'd0, ia.done, ib.done}, {30'd0, dn && !m_b, dn && m_b});
      check_eq("a_rdata", {16'd0, ia.rdata}, {16'd0, m_rd_a});
      check_eq("b_rdata", {16'd0, ib.rdata}, {16'd0, m_rd_b});
      if (acc) check_eq("addr", {12'd0, addr_o}, {12'd0, m_addr});
      if (acc && m_we) check_eq("wdata_bus", {16'd0, sram_data}, {16'd0, m_wdata});
    end
  end

  task automatic set_req(input bit pb, input bit r, input bit w, input logic [19:0] a,
                         input logic [15:0] d);
    if (pb) begin
      ib.req = r; ib.we = w; ib.addr = a; ib.wdata = d;
    end else begin
      ia.req = r; ia.we = w; ia.addr = a; ia.wdata = d;
    end
  endtask

  // done_cycle: index of the Done cycle counting the first cycle after the grant edge as 1.
  task automatic run_access(input bit pb, input bit w, input logic [19:0] a, input logic [15:0] d,
                            input bit drop_early, output int done_cycle, output int wr_cycles);
    int gnt_at;
    gnt_at     = -1;
    done_cycle = -1;
    wr_cycles  = 0;
    set_req(pb, 1'b1, w, a, d);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((pb ? ib.gnt : ia.gnt) && gnt_at < 0) begin
        gnt_at = k;
        if (drop_early) begin
          if (pb) ib.req = 1'b0; else ia.req = 1'b0;
        end
      end
      if (!we_n && sram_data == d) wr_cycles++;
      if (pb ? ib.done : ia.done) begin
        done_cycle = k - gnt_at + 1;
        break;
      end
    end
    if (pb) ib.req = 1'b0; else ia.req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          dc;
    int          wc;
    int          gp [4];
    int          gt [4];
    int          ng;
    bit          pa, pb_prev;
    bit          pend_a, pend_b;
    logic [19:0] ra;

    set_req(1'b0, 1'b0, 1'b0, 20'd0, 16'd0);
    set_req(1'b1, 1'b0, 1'b0, 20'd0, 16'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_strobes", {27'd0, ce_n, ub_n, lb_n, oe_n, we_n}, 32'h1F);
    check_eq("rst_gnt_done", {28'd0, ia.gnt, ib.gnt, ia.done, ib.done}, 32'h0);
    check_eq("rst_rdata", {ia.rdata, ib.rdata}, 32'h0);
    check_eq("rst_addr", {12'd0, addr_o}, 32'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    run_access(1'b0, 1'b1, 20'h00003, 16'h1234, 1'b0, dc, wc);
    $display("txn A write 0x00003=1234 done_cycle=%0d write_cycles=%0d", dc, wc);
    check_eq("a_write_done_cycle", dc, 3);
    check_eq("a_write_bus_cycles", wc, 2);
    @(negedge clk);
    run_access(1'b1, 1'b0, 20'h00003, 16'h0000, 1'b0, dc, wc);
    $display("txn B read 0x00003 -> %h done_cycle=%0d", ib.rdata, dc);
    check_eq("b_read_done_cycle", dc, 3);
    check_eq("b_read_data", {16'd0, ib.rdata}, 32'h1234);
    check_eq("a_rdata_held", {16'd0, ia.rdata}, 32'h0);

    pulse_reset();
    set_req(1'b0, 1'b1, 1'b0, 20'h00005, 16'd0);
    set_req(1'b1, 1'b1, 1'b0, 20'h00006, 16'd0);
    ng = 0; pa = 1'b0; pb_prev = 1'b0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if (ia.gnt && !pa)      begin gp[ng] = 0; gt[ng] = k; ng++; end
      else if (ib.gnt && !pb_prev) begin gp[ng] = 1; gt[ng] = k; ng++; end
      pa = ia.gnt; pb_prev = ib.gnt;
    end
    ia.req = 1'b0; ib.req = 1'b0;
    $display("txn contention grants=%0d order=%0d%0d%0d%0d", ng, gp[0], gp[1], gp[2], gp[3]);
    check_eq("contention_grants", ng, 4);
    for (int i = 0; i < 4; i++) check_eq("contention_order", gp[i], i % 2);
    for (int i = 0; i < 3; i++) check_eq("contention_period", gt[i+1] - gt[i], 4);
    repeat (6) @(negedge clk);

    run_access(1'b1, 1'b0, 20'h00007, 16'h0000, 1'b1, dc, wc);
    $display("txn B read 0x00007 dropped req -> %h done_cycle=%0d", ib.rdata, dc);
    check_eq("drop_done_cycle", dc, 3);
    check_eq("drop_read_data", {16'd0, ib.rdata}, 32'hA207);

    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 20'h00009, 16'hBEEF);
    for (int k = 0; k < 10 && !ia.gnt; k++) @(negedge clk);
    @(negedge clk);
    check_eq("midwrite_we_low", {31'd0, we_n}, 32'h0);
    #1 rst = 1'b1;
    #1;
    check_eq("midwrite_async_strobes", {27'd0, ce_n, ub_n, lb_n, oe_n, we_n}, 32'h1F);
    check_eq("midwrite_async_gnt", {30'd0, ia.gnt, ib.gnt}, 32'h0);
    ia.req = 1'b0;
    @(negedge clk);
    check_eq("midwrite_no_done", {30'd0, ia.done, ib.done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_access(1'b0, 1'b0, 20'h00009, 16'h0000, 1'b0, dc, wc);
    $display("txn A read 0x00009 after reset -> %h done_cycle=%0d", ia.rdata, dc);
    check_eq("post_reset_done_cycle", dc, 3);
    check_eq("post_reset_read", {16'd0, ia.rdata}, 32'hAC09);

    @(negedge clk);
    pend_a = 1'b0; pend_b = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (ia.done) begin
        check_eq("a_done_owner", {31'd0, pend_a}, 32'h1);
        pend_a = 1'b0; ia.req = 1'b0;
      end else if (pend_a && ia.gnt && ia.req && $urandom_range(0, 7) == 0) begin
        ia.req = 1'b0;
      end else if (!pend_a && $urandom_range(0, 2) == 0) begin
        ra = 20'($urandom_range(0, 31)) | ($urandom_range(0, 1) == 1 ? 20'hFFFE0 : 20'h0);
        pend_a = 1'b1;
        set_req(1'b0, 1'b1, 1'($urandom_range(0, 1)), ra, 16'($urandom));
      end
      if (ib.done) begin
        check_eq("b_done_owner", {31'd0, pend_b}, 32'h1);
        pend_b = 1'b0; ib.req = 1'b0;
      end else if (pend_b && ib.gnt && ib.req && $urandom_range(0, 7) == 0) begin
        ib.req = 1'b0;
      end else if (!pend_b && $urandom_range(0, 2) == 0) begin
        ra = 20'($urandom_range(0, 31)) | ($urandom_range(0, 1) == 1 ? 20'hFFFE0 : 20'h0);
        pend_b = 1'b1;
        set_req(1'b1, 1'b1, 1'($urandom_range(0, 1)), ra, 16'($urandom));
      end
    end
    ia.req = 1'b0; ib.req = 1'b0;
    repeat (8) @(negedge clk);
    $display("txn random traffic 10000 cycles complete");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, SHALL set the number of clock cycles the SRAM strobes are held per access; legal range 1..15.
REQ-002 Clk  in  1  single system clock; all state SHALL change on its rising edge, except on reset.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 A_Req / B_Req  in  1 each  access request from port A (CPU) / port B (loader/debug).
REQ-005 A_WE / B_WE  in  1 each  1 = write, 0 = read; sampled with the request.
REQ-006 A_Addr / B_Addr  in  20 each  word address.
REQ-007 A_WData / B_WData  in  16 each  write data.
REQ-008 A_RData / B_RData  out  16 each  registered read data, valid from the Done cycle until that port's next read completes.
REQ-009 A_Done / B_Done  out  1 each  one-cycle completion pulse.
REQ-010 A_Gnt / B_Gnt  out  1 each  high while the SRAM is committed to that port (ACCESS and DONE states).
REQ-011 CE, UB, LB, OE, WE  out  1 each  active-low SRAM strobes.
REQ-012 ADDR  out  20  SRAM address.
REQ-013 Data  inout  16  SRAM data bus; driven only during write ACCESS, otherwise high-Z.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS and DONE; there are no other states.
REQ-015 IDLE: with no request, stay in IDLE; with exactly one request, grant that port; with both requesting, grant the port not served last (round-robin).
REQ-016 The last-served pointer SHALL reset to B, so that A wins the first simultaneous contention.
REQ-017 On the grant edge, the granted port's WE, Addr and WData SHALL be latched and the FSM SHALL enter ACCESS; later changes to the request inputs have no effect on the access in progress.
REQ-018 ACCESS: CE=0, UB=0, LB=0, ADDR = latched address, for exactly ACCESS_CYCLES cycles, counted by an internal down-counter.
REQ-019 Read ACCESS: OE=0, WE=1, Data high-Z; the Data bus SHALL be captured into the granted port's RData on the final ACCESS edge.
REQ-020 Write ACCESS: OE=1, WE=0, Data driven with the latched write data for every ACCESS cycle.
REQ-021 DONE: lasts exactly one cycle, with all strobes high and Data high-Z (bus turnaround); the granted port's Done=1 and the FSM then returns to IDLE.
REQ-022 Latency SHALL be fixed: Done is asserted ACCESS_CYCLES+1 cycles after the grant edge, and the next grant occurs no earlier than the cycle after DONE.
REQ-023 Minimum back-to-back period per access SHALL be ACCESS_CYCLES+2 cycles; if both ports request continuously, grants SHALL alternate A,B,A,B.
REQ-024 A requester that drops Req mid-access SHALL NOT abort it; the access completes and Done still pulses.
REQ-025 A requester SHALL keep Req high until its Done; a Req still high in the IDLE cycle after DONE is treated as a new request.
REQ-026 Only the granted port's Gnt, Done and RData SHALL change; the other port's RData is held.
REQ-027 At most one of A_Gnt/B_Gnt and at most one of A_Done/B_Done SHALL ever be high.
REQ-028 Data SHALL never be driven while OE=0.

Reset
REQ-029 While Reset=1, asynchronously: FSM=IDLE, last-served=B, counter=0, CE=UB=LB=OE=WE=1, ADDR=0, Data high-Z, Gnt=0, Done=0, A_RData=B_RData=0.
REQ-030 Reset asserted mid-ACCESS SHALL abort the access immediately, with no Done pulse and no RData update.
REQ-031 After Reset deasserts, the first rising edge with a request pending SHALL grant per REQ-015.

Verification
REQ-032 Single write: A writes 0x1234 to 0x00003 (ACCESS_CYCLES=2) -> WE=0 and Data=0x1234 for 2 cycles, A_Done 3 cycles after the grant edge; a B read of 0x00003 then returns B_RData=0x1234.
REQ-033 Contention: A and B request on the same edge after reset -> A served first, then B; continuous requests alternate A,B,A,B with a 4-cycle period.
REQ-034 Request drop: B_Req pulled low in the 1st ACCESS cycle -> access completes, B_Done pulses, strobes are normal.
REQ-035 Reset mid-write: Reset asserted in the 2nd ACCESS cycle -> WE/CE go high and Data goes high-Z without waiting for a clock edge; no Done; the next A request is granted normally.
REQ-036 Bus discipline: random mixed traffic for 10k cycles -> no cycle with Data driven while OE=0, Gnt and Done one-hot-or-zero, each Done matches exactly one Req.
